// File: rtl/decode_hazard_ctrl.sv
// Decode-stage pipeline sequencer: forwarding selects, load-use/branch hazard
// stalls, multi-cycle MUL/DIV hold FSM and decode-resolved redirect sequencing.
module decode_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 65,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_use_rs1,
  input  logic        d_use_rs2,
  input  logic        d_branch_op,
  input  logic        d_taken,
  input  logic [63:0] d_pcbranch,
  input  logic        e_valid,
  input  logic        e_wen,
  input  logic [4:0]  e_dst,
  input  logic        e_is_load,
  input  logic        e_is_mul,
  input  logic        e_is_div,
  input  logic        m_valid,
  input  logic        m_wen,
  input  logic [4:0]  m_dst,
  input  logic        dmem_busy,
  input  logic        imem_busy,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        bubble_e,
  output logic        hold_e,
  output logic        stall_m,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
);

  // Latencies below 2 never need the FSM; the instruction leaves execute in one cycle.
  localparam bit               MulMc   = (MUL_LAT >= 2);
  localparam bit               DivMc   = (DIV_LAT >= 2);
  localparam logic [CNT_W-1:0] MulInit = MulMc ? CNT_W'(MUL_LAT - 2) : '0;
  localparam logic [CNT_W-1:0] DivInit = DivMc ? CNT_W'(DIV_LAT - 2) : '0;

  typedef enum logic [0:0] {StIdle, StRun} mc_state_e;

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [63:0]      redir_pc_q, redir_pc_d;

  logic       e_match_rs1, e_match_rs2, m_match_rs1, m_match_rs2;
  logic       haz, mc_start, mc_hold, stall_any, take;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign e_match_rs1 = e_valid & e_wen & (e_dst == d_rs1) & (d_rs1 != 5'd0);
  assign e_match_rs2 = e_valid & e_wen & (e_dst == d_rs2) & (d_rs2 != 5'd0);
  assign m_match_rs1 = m_valid & m_wen & (m_dst == d_rs1) & (d_rs1 != 5'd0);
  assign m_match_rs2 = m_valid & m_wen & (m_dst == d_rs2) & (d_rs2 != 5'd0);

  // Operand forwarding; a load result in execute is not ready yet, so it cannot forward.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
    if (e_match_rs1 && !e_is_load) fwd_a_raw = 2'b01;
    else if (m_match_rs1)          fwd_a_raw = 2'b10;
    if (e_match_rs2 && !e_is_load) fwd_b_raw = 2'b01;
    else if (m_match_rs2)          fwd_b_raw = 2'b10;
  end

  // Load-use, or a decode branch needing an execute result (no E->D compare path).
  assign haz = d_valid & (e_is_load | d_branch_op) &
               ((d_use_rs1 & e_match_rs1) | (d_use_rs2 & e_match_rs2));

  // Multi-cycle start request; DIV class takes precedence when selecting the latency.
  assign mc_start = e_valid & (e_is_div ? DivMc : (e_is_mul & MulMc)) & ~dmem_busy;

  // MC FSM state and counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MC FSM next state; a busy data memory freezes everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!dmem_busy) begin
      unique case (state_q)
        StIdle: begin
          if (mc_start) begin
            state_d = StRun;
            cnt_d   = e_is_div ? DivInit : MulInit;
          end
        end
        StRun: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // MC FSM output: hold execute on the start cycle and while the counter is non-zero.
  always_comb begin
    mc_hold = 1'b0;
    unique case (state_q)
      StIdle:  mc_hold = mc_start;
      StRun:   mc_hold = (cnt_q != '0);
      default: mc_hold = 1'b0;
    endcase
  end

  assign stall_any = dmem_busy | mc_hold | haz;
  // A pending redirect means decode holds a flushed slot, so no new take can arise.
  assign take      = d_valid & d_branch_op & d_taken & ~stall_any & ~redir_pend_q;

  // Pending-redirect register, used when fetch is busy at the time of the take.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  // Pending redirect retires only once it is actually delivered to fetch.
  always_comb begin
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    if (redir_pend_q) begin
      if (!stall_any && !imem_busy) redir_pend_d = 1'b0;
    end else if (take && imem_busy) begin
      redir_pend_d = 1'b1;
      redir_pc_d   = d_pcbranch;
    end
  end

  // Pipeline controls in priority order; everything is forced low during reset.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    flush_d        = 1'b0;
    bubble_e       = 1'b0;
    hold_e         = 1'b0;
    stall_m        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fwd_a          = 2'b00;
    fwd_b          = 2'b00;
    if (!reset) begin
      fwd_a    = fwd_a_raw;
      fwd_b    = fwd_b_raw;
      stall_f  = stall_any;
      stall_d  = stall_any;
      hold_e   = dmem_busy | mc_hold;
      stall_m  = dmem_busy;
      bubble_e = haz & ~dmem_busy & ~mc_hold;
      flush_d  = take | redir_pend_q;
      if (redir_pend_q) begin
        redirect_pc    = redir_pc_q;
        redirect_valid = ~imem_busy & ~stall_any;
      end else if (take) begin
        redirect_pc    = d_pcbranch;
        redirect_valid = ~imem_busy;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the pipeline rules.
module tb_decode_hazard_ctrl;

  localparam int unsigned MulLat = 3;
  localparam int unsigned DivLat = 65;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid, d_use_rs1, d_use_rs2, d_branch_op, d_taken;
  logic [4:0]  d_rs1, d_rs2, e_dst, m_dst;
  logic [63:0] d_pcbranch;
  logic        e_valid, e_wen, e_is_load, e_is_mul, e_is_div, m_valid, m_wen;
  logic        dmem_busy, imem_busy;

  logic        stall_f, stall_d, flush_d, bubble_e, hold_e, stall_m, redirect_valid;
  logic [63:0] redirect_pc;
  logic [1:0]  fwd_a, fwd_b;

  logic        stall_f1, stall_d1, flush_d1, bubble_e1, hold_e1, stall_m1, redirect_valid1;
  logic [63:0] redirect_pc1;
  logic [1:0]  fwd_a1, fwd_b1;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.MUL_LAT(MulLat), .DIV_LAT(DivLat), .CNT_W(7)) u_dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_branch_op(d_branch_op),
    .d_taken(d_taken), .d_pcbranch(d_pcbranch), .e_valid(e_valid), .e_wen(e_wen),
    .e_dst(e_dst), .e_is_load(e_is_load), .e_is_mul(e_is_mul), .e_is_div(e_is_div),
    .m_valid(m_valid), .m_wen(m_wen), .m_dst(m_dst), .dmem_busy(dmem_busy),
    .imem_busy(imem_busy), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .bubble_e(bubble_e), .hold_e(hold_e), .stall_m(stall_m),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // Single-cycle MUL/DIV variant: its execute hold must track dmem_busy only.
  decode_hazard_ctrl #(.MUL_LAT(1), .DIV_LAT(1), .CNT_W(7)) u_dut1 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_branch_op(d_branch_op),
    .d_taken(d_taken), .d_pcbranch(d_pcbranch), .e_valid(e_valid), .e_wen(e_wen),
    .e_dst(e_dst), .e_is_load(e_is_load), .e_is_mul(e_is_mul), .e_is_div(e_is_div),
    .m_valid(m_valid), .m_wen(m_wen), .m_dst(m_dst), .dmem_busy(dmem_busy),
    .imem_busy(imem_busy), .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1),
    .bubble_e(bubble_e1), .hold_e(hold_e1), .stall_m(stall_m1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1), .fwd_a(fwd_a1),
    .fwd_b(fwd_b1)
  );

  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  // Model state: execute cycles still owed by the multi-cycle op (0 = none), pending redirect.
  int          rem;
  bit          pend;
  logic [63:0] pend_pc;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, name, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (e_valid && e_wen && !e_is_load && e_dst == src) return 2'b01;
    if (m_valid && m_wen && m_dst == src) return 2'b10;
    return 2'b00;
  endfunction

  // Compare every output against the model for the current inputs, then advance the model.
  task automatic check_all();
    logic [1:0]  xfa, xfb;
    logic        xhaz, xmc, xstall, xbub, xtake, xflush, xrv;
    logic [63:0] xrpc;
    logic [4:0]  srcs [2];
    logic        uses [2];
    int          lat;
    bit          start;
    if (reset) begin
      rem = 0; pend = 0; pend_pc = '0;
      xfa = 0; xfb = 0; xstall = 0; xbub = 0; xflush = 0; xrv = 0; xrpc = '0; xmc = 0;
      chk("hold_e", {63'd0, hold_e}, 64'd0);
      chk("stall_m", {63'd0, stall_m}, 64'd0);
    end else begin
      srcs[0] = d_rs1; srcs[1] = d_rs2; uses[0] = d_use_rs1; uses[1] = d_use_rs2;
      xfa = model_fwd(d_rs1);
      xfb = model_fwd(d_rs2);
      xhaz = 1'b0;
      for (int i = 0; i < 2; i++)
        if (d_valid && uses[i] && srcs[i] != 0 && e_valid && e_wen && e_dst == srcs[i] &&
            (e_is_load || d_branch_op)) xhaz = 1'b1;
      lat   = e_is_div ? DivLat : (e_is_mul ? MulLat : 0);
      start = e_valid && (e_is_mul || e_is_div) && lat >= 2 && !dmem_busy;
      xmc   = (rem == 0) ? start : (rem > 1);
      xstall = dmem_busy || xmc || xhaz;
      xbub   = xhaz && !dmem_busy && !xmc;
      xtake  = !xstall && !pend && d_valid && d_branch_op && d_taken;
      xflush = xtake || pend;
      xrv    = !xstall && (pend || xtake) && !imem_busy;
      xrpc   = pend ? pend_pc : (xtake ? d_pcbranch : 64'd0);
      chk("hold_e", {63'd0, hold_e}, {63'd0, dmem_busy | xmc});
      chk("stall_m", {63'd0, stall_m}, {63'd0, dmem_busy});
      if (!dmem_busy) begin
        if (rem == 0 && start) rem = lat - 1;
        else if (rem > 0) rem--;
      end
      if (pend) begin
        if (!xstall && !imem_busy) pend = 0;
      end else if (xtake && imem_busy) begin
        pend = 1; pend_pc = d_pcbranch;
      end
    end
    chk("fwd_a", {62'd0, fwd_a}, {62'd0, xfa});
    chk("fwd_b", {62'd0, fwd_b}, {62'd0, xfb});
    chk("stall_f", {63'd0, stall_f}, {63'd0, xstall});
    chk("stall_d", {63'd0, stall_d}, {63'd0, xstall});
    chk("bubble_e", {63'd0, bubble_e}, {63'd0, xbub});
    chk("flush_d", {63'd0, flush_d}, {63'd0, xflush});
    chk("redirect_valid", {63'd0, redirect_valid}, {63'd0, xrv});
    chk("redirect_pc", redirect_pc, xrpc);
    chk("lat1.hold_e", {63'd0, hold_e1}, {63'd0, dmem_busy & ~reset});
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_use_rs1 = 0; d_use_rs2 = 0;
    d_branch_op = 0; d_taken = 0; d_pcbranch = '0;
    e_valid = 0; e_wen = 0; e_dst = 0; e_is_load = 0; e_is_mul = 0; e_is_div = 0;
    m_valid = 0; m_wen = 0; m_dst = 0; dmem_busy = 0; imem_busy = 0;
  endtask

  task automatic random_inputs();
    d_valid = 1'($urandom); d_rs1 = 5'($urandom_range(0, 3)); d_rs2 = 5'($urandom_range(0, 3));
    d_use_rs1 = 1'($urandom); d_use_rs2 = 1'($urandom);
    d_branch_op = 1'($urandom); d_taken = 1'($urandom);
    d_pcbranch = {$urandom, $urandom};
    e_valid = 1'($urandom); e_wen = 1'($urandom); e_dst = 5'($urandom_range(0, 3));
    e_is_load = ($urandom_range(0, 3) == 0);
    e_is_mul = ($urandom_range(0, 3) == 0);
    e_is_div = ($urandom_range(0, 15) == 0);
    m_valid = 1'($urandom); m_wen = 1'($urandom); m_dst = 5'($urandom_range(0, 3));
    dmem_busy = ($urandom_range(0, 7) == 0);
    imem_busy = 1'($urandom);
  endtask

  int holds, flushes;

  initial begin
    clear_inputs();
    rem = 0; pend = 0; pend_pc = '0;
    reset = 1;
    // Inputs that would forward and stall if reset did not force outputs low.
    d_valid = 1; d_rs1 = 5; d_use_rs1 = 1; d_branch_op = 1;
    e_valid = 1; e_wen = 1; e_dst = 5; dmem_busy = 1;
    next_cycle();
    phase = "reset"; settle(); next_cycle();
    reset = 0;

    phase = "fwd_e"; clear_inputs();
    e_valid = 1; e_wen = 1; e_dst = 5; d_rs1 = 5;
    settle(); chk("fwd_a_direct", {62'd0, fwd_a}, 64'd1); next_cycle();

    phase = "fwd_m"; e_dst = 6; m_valid = 1; m_wen = 1; m_dst = 5;
    settle(); chk("fwd_a_direct", {62'd0, fwd_a}, 64'd2); next_cycle();

    phase = "fwd_x0"; clear_inputs(); e_valid = 1; e_wen = 1;
    m_valid = 1; m_wen = 1;
    settle(); chk("fwd_a_direct", {62'd0, fwd_a}, 64'd0); next_cycle();

    phase = "load_use"; clear_inputs();
    e_valid = 1; e_wen = 1; e_is_load = 1; e_dst = 7; d_valid = 1; d_rs2 = 7; d_use_rs2 = 1;
    settle();
    chk("lu_bubble", {63'd0, bubble_e}, 64'd1);
    chk("lu_stall", {63'd0, stall_d}, 64'd1);
    next_cycle();
    e_valid = 0; e_is_load = 0; m_valid = 1; m_wen = 1; m_dst = 7;
    phase = "load_in_m"; settle();
    chk("lm_stall", {63'd0, stall_f}, 64'd0);
    chk("lm_fwd_b", {62'd0, fwd_b}, 64'd2);
    next_cycle();

    phase = "div"; clear_inputs(); e_valid = 1; e_is_div = 1; holds = 0;
    for (int i = 0; i < 65; i++) begin
      settle();
      if (hold_e) holds++;
      if (i == 64) chk("div_last", {63'd0, hold_e}, 64'd0);
      next_cycle();
    end
    chk("div_holds", 64'(holds), 64'd64);
    e_valid = 0; e_is_div = 0;
    phase = "div_idle"; settle(); chk("idle_hold", {63'd0, hold_e}, 64'd0); next_cycle();

    phase = "mul"; e_valid = 1; e_is_mul = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mul_hold", {63'd0, hold_e}, (i < 2) ? 64'd1 : 64'd0);
      chk("mul1_hold", {63'd0, hold_e1}, 64'd0);
      next_cycle();
    end
    clear_inputs(); settle(); next_cycle();

    phase = "branch"; d_valid = 1; d_branch_op = 1; d_taken = 1;
    d_pcbranch = 64'h8000_0000_0000_1234; imem_busy = 1; flushes = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      if (flush_d) flushes++;
      chk("br_rv", {63'd0, redirect_valid}, (i == 3) ? 64'd1 : 64'd0);
      if (i == 3) chk("br_pc", redirect_pc, 64'h8000_0000_0000_1234);
      next_cycle();
      d_valid = 0; d_pcbranch = 64'hdead;
      imem_busy = (i < 2);
    end
    chk("br_flushes", 64'(flushes), 64'd4);

    phase = "dmem_run"; clear_inputs(); e_valid = 1; e_is_div = 1;
    for (int i = 0; i < 54; i++) begin settle(); next_cycle(); end
    dmem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("dm_all", {60'd0, stall_f, stall_d, hold_e, stall_m}, 64'hf);
      next_cycle();
    end
    dmem_busy = 0; holds = 0;
    for (int i = 0; i < 11; i++) begin
      settle();
      if (hold_e) holds++;
      if (i == 10) chk("dm_last", {63'd0, hold_e}, 64'd0);
      next_cycle();
    end
    chk("dm_holds", 64'(holds), 64'd10);
    clear_inputs(); settle(); next_cycle();

    phase = "rst_run"; e_valid = 1; e_is_div = 1;
    for (int i = 0; i < 5; i++) begin settle(); next_cycle(); end
    #2 reset = 1;
    settle(); chk("rr_hold", {63'd0, hold_e}, 64'd0);
    next_cycle(); reset = 0; clear_inputs();
    settle(); chk("rr_idle", {63'd0, hold_e}, 64'd0); next_cycle();

    phase = "rst_pend"; d_valid = 1; d_branch_op = 1; d_taken = 1;
    d_pcbranch = 64'h4444; imem_busy = 1;
    settle(); next_cycle();
    d_valid = 0; settle(); next_cycle();
    #2 reset = 1;
    settle(); next_cycle();
    reset = 0; imem_busy = 0;
    settle();
    chk("rp_rv", {63'd0, redirect_valid}, 64'd0);
    chk("rp_flush", {63'd0, flush_d}, 64'd0);
    next_cycle();

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      reset = ($urandom_range(0, 199) == 0);
      settle();
      next_cycle();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
